div_sequencer: RTL and testbench

Multi-cycle integer divide sequencer for the execute stage of the 6-stage pipeline. It accepts DIV.W/DIV.WU/MOD.W/MOD.WU requests from the execute stage and runs a fixed-latency radix-2 restoring divide on a locally owned datapath. It reports completion and drives the divide-stall signal into the hazard detection unit as es_div_stall. It also handles pipeline cancellation and the LoongArch sign and corner-case rules.

---
 rtl/div_sequencer_if.sv | 28 ++
 rtl/div_sequencer.sv | 144 ++++++++++++++
 tb/tb_div_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/div_sequencer_if.sv
// Divide request/response bundle between the execute stage and div_sequencer.
//   master : execute stage (drives request, cancel; observes stall/done/result)
//   slave  : div_sequencer
//   div_valid/div_op/div_src1/div_src2/div_cancel : request side
//   div_stall/div_done/div_result/div_busy        : response side
interface div_sequencer_if #(
  parameter int unsigned DIV_W = 32
);
  logic             div_valid;
  logic [1:0]       div_op;
  logic [DIV_W-1:0] div_src1;
  logic [DIV_W-1:0] div_src2;
  logic             div_cancel;
  logic             div_stall;
  logic             div_done;
  logic [DIV_W-1:0] div_result;
  logic             div_busy;

  modport master (
    output div_valid, div_op, div_src1, div_src2, div_cancel,
    input  div_stall, div_done, div_result, div_busy
  );

  modport slave (
    input  div_valid, div_op, div_src1, div_src2, div_cancel,
    output div_stall, div_done, div_result, div_busy
  );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for DIV.W/DIV.WU/MOD.W/MOD.WU.
// Fixed latency: accept in IDLE, DIV_W BUSY steps, one DONE cycle.
//   clk     : clock, rising edge
//   resetn  : synchronous active-low reset
//   bus     : div_sequencer_if.slave
//     div_op[1] 1=remainder 0=quotient, div_op[0] 1=unsigned 0=signed
//     div_stall  = div_valid & ~div_done & ~div_cancel (combinational)
//     div_done   one-cycle pulse, div_result valid with it
//     div_result held until the next completion
//     div_busy   high while in BUSY
module div_sequencer #(
  parameter int unsigned DIV_W = 32
) (
  input logic          clk,
  input logic          resetn,
  div_sequencer_if.slave bus
);
  localparam int unsigned CW = $clog2(DIV_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             op_mod;
  logic             q_neg;
  logic             r_neg;
  logic             dz;
  logic [DIV_W-1:0] src1_raw;
  logic [DIV_W-1:0] divisor;
  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] quo;
  logic             done;
  logic             busy;
  logic [DIV_W-1:0] result;

  logic             is_signed;
  logic [DIV_W-1:0] abs1;
  logic [DIV_W-1:0] abs2;
  logic [DIV_W:0]   rem_sh;
  logic [DIV_W-1:0] step_rem;
  logic [DIV_W-1:0] step_quo;
  logic [DIV_W-1:0] fix_quo;
  logic [DIV_W-1:0] fix_rem;
  logic [DIV_W-1:0] final_val;

  always_comb begin
    is_signed = ~bus.div_op[0];
    abs1 = (is_signed && bus.div_src1[DIV_W-1]) ? -bus.div_src1 : bus.div_src1;
    abs2 = (is_signed && bus.div_src2[DIV_W-1]) ? -bus.div_src2 : bus.div_src2;

    // Shifted remainder needs DIV_W+1 bits; the trial test is an unsigned
    // compare, and when it passes the true difference is below the divisor,
    // so a DIV_W-bit subtract gives the exact new remainder.
    rem_sh = {rem, quo[DIV_W-1]};
    if (rem_sh >= {1'b0, divisor}) begin
      step_rem = rem_sh[DIV_W-1:0] - divisor;
      step_quo = {quo[DIV_W-2:0], 1'b1};
    end else begin
      step_rem = rem_sh[DIV_W-1:0];
      step_quo = {quo[DIV_W-2:0], 1'b0};
    end

    fix_quo = q_neg ? -step_quo : step_quo;
    fix_rem = r_neg ? -step_rem : step_rem;
    if (dz)
      final_val = op_mod ? src1_raw : '1;
    else
      final_val = op_mod ? fix_rem : fix_quo;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      op_mod   <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dz       <= 1'b0;
      src1_raw <= '0;
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      if (bus.div_cancel) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.div_valid) begin
              op_mod   <= bus.div_op[1];
              q_neg    <= is_signed & (bus.div_src1[DIV_W-1] ^ bus.div_src2[DIV_W-1]);
              r_neg    <= is_signed & bus.div_src1[DIV_W-1];
              dz       <= (bus.div_src2 == '0);
              src1_raw <= bus.div_src1;
              divisor  <= abs2;
              quo      <= abs1;
              rem      <= '0;
              cnt      <= '0;
              state    <= BUSY;
              busy     <= 1'b1;
            end
          end
          BUSY: begin
            if (!bus.div_valid) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              rem <= step_rem;
              quo <= step_quo;
              cnt <= cnt + 1'b1;
              if (cnt == CW'(DIV_W - 1)) begin
                state  <= DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= final_val;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.div_stall  = bus.div_valid & ~done & ~bus.div_cancel;
  assign bus.div_done   = done;
  assign bus.div_result = result;
  assign bus.div_busy   = busy;
endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;
  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_bad;
  int   cyc_abs;

  div_sequencer_if #(.DIV_W(32)) bus ();

  div_sequencer #(.DIV_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_abs = 0;
  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; that cycle is cycle 0. Returns with the
  // request dropped #1 after the edge that follows div_done.
  task automatic do_div(input string name, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, output int done_abs);
    bit seen;
    bit stall_bad;
    done_abs = -1;
    bus.div_valid = 1'b1;
    bus.div_op    = op;
    bus.div_src1  = a;
    bus.div_src2  = b;
    seen = 0;
    stall_bad = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (c == 5) chk({name, "_busy"}, 32'(bus.div_busy), 32'd1);
      if (bus.div_done) begin
        seen = 1;
        done_abs = cyc_abs;
        chk({name, "_latency"}, 32'(c), 32'd33);
        chk({name, "_stall_in_done"}, 32'(bus.div_stall), 32'd0);
        chk({name, "_result"}, bus.div_result, exp);
      end else if (!bus.div_stall) begin
        stall_bad = 1;
      end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_stall_window"}, 32'(stall_bad), 32'd0);
    @(posedge clk);
    #1;
    bus.div_valid = 1'b0;
  endtask

  initial begin
    int d0;
    int d1;
    bit spurious;
    n_cmp = 0;
    n_bad = 0;

    vecs[0]  = '{2'b01, 32'd100, 32'd7, 32'd14};
    vecs[1]  = '{2'b11, 32'd100, 32'd7, 32'd2};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
    vecs[4]  = '{2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1};
    vecs[5]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    vecs[7]  = '{2'b00, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF};
    vecs[8]  = '{2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678};
    vecs[9]  = '{2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB};
    vecs[10] = '{2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
    vecs[11] = '{2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE};
    vecs[12] = '{2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1};
    vecs[13] = '{2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14};
    vecs[14] = '{2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE};

    resetn = 1'b0;
    bus.div_valid  = 1'b0;
    bus.div_op     = 2'b00;
    bus.div_src1   = '0;
    bus.div_src2   = '0;
    bus.div_cancel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_done", 32'(bus.div_done), 32'd0);
    chk("reset_busy", 32'(bus.div_busy), 32'd0);
    chk("reset_result", bus.div_result, 32'd0);
    chk("reset_stall", 32'(bus.div_stall), 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      do_div($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, d0);
      @(posedge clk);
      #1;
    end

    // Cancel at BUSY cycle 10; result must keep the last value (0xFFFFFFFE).
    bus.div_valid = 1'b1;
    bus.div_op    = 2'b01;
    bus.div_src1  = 32'd1000;
    bus.div_src2  = 32'd3;
    spurious = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.div_done) spurious = 1;
      @(posedge clk);
      #1;
    end
    bus.div_cancel = 1'b1;
    @(negedge clk);
    chk("cancel_stall_low", 32'(bus.div_stall), 32'd0);
    @(posedge clk);
    #1;
    bus.div_cancel = 1'b0;
    bus.div_valid  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.div_done) spurious = 1;
      if (c == 0) chk("cancel_busy", 32'(bus.div_busy), 32'd0);
    end
    chk("cancel_no_done", 32'(spurious), 32'd0);
    chk("cancel_result_held", bus.div_result, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    do_div("after_cancel", 2'b01, 32'd50, 32'd5, 32'd10, d0);

    // Back-to-back: second request starts the cycle after the first DONE.
    @(posedge clk);
    #1;
    do_div("b2b_first", 2'b01, 32'd1000, 32'd10, 32'd100, d0);
    do_div("b2b_second", 2'b01, 32'd81, 32'd9, 32'd9, d1);
    chk("b2b_gap", 32'(d1 - d0), 32'd34);

    // Reset pulse at BUSY cycle 20.
    @(posedge clk);
    #1;
    bus.div_valid = 1'b1;
    bus.div_op    = 2'b01;
    bus.div_src1  = 32'd77;
    bus.div_src2  = 32'd7;
    spurious = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.div_done) spurious = 1;
      @(posedge clk);
      #1;
    end
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    bus.div_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_done", 32'(bus.div_done), 32'd0);
    chk("rst_mid_busy", 32'(bus.div_busy), 32'd0);
    chk("rst_mid_result", bus.div_result, 32'd0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.div_done) spurious = 1;
    end
    chk("rst_mid_no_done", 32'(spurious), 32'd0);
    @(posedge clk);
    #1;
    do_div("after_reset", 2'b00, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, d0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
